// File: rtl/servant_spi_wb_bridge.sv
// rtl/servant_spi_wb_bridge.sv - SPI slave (mode 0) to Wishbone master bridge for single-word access
// All SPI pins are oversampled in the wb_clk domain; no logic runs on spi_sck.
module servant_spi_wb_bridge #(
    parameter int ADDRESS_WIDTH = 24,
    parameter int SYNC_STAGES   = 2
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        spi_sck,
    input  logic        spi_cs,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    output logic        o_err
);

    localparam int         ADDR_BYTES = ADDRESS_WIDTH / 8;
    localparam logic [1:0] ADDR_LAST  = 2'(ADDR_BYTES - 1);
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_READ   = 8'h03;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_WB_WR,
        ST_RWAIT,
        ST_RDATA,
        ST_IGNORE,
        ST_DRAIN
    } state_t;

    state_t                     state_q, state_d;
    logic [SYNC_STAGES-1:0]     sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0]     cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0]     mosi_sync_q, mosi_sync_d;
    logic                       sck_prev_q, sck_prev_d;
    logic                       cs_prev_q, cs_prev_d;
    logic [2:0]                 bit_cnt_q, bit_cnt_d;
    logic [1:0]                 byte_idx_q, byte_idx_d;
    logic [6:0]                 rx_q, rx_d;
    logic                       is_read_q, is_read_d;
    logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]                tx_q, tx_d;
    logic                       rd_valid_q, rd_valid_d;
    logic                       first_fall_q, first_fall_d;
    logic                       blank_q, blank_d;
    logic                       miso_q, miso_d;
    logic                       err_q, err_d;
    logic                       wb_cyc_q, wb_cyc_d;
    logic                       wb_we_q, wb_we_d;
    logic [3:0]                 wb_sel_q, wb_sel_d;
    logic [31:0]                wb_adr_q, wb_adr_d;
    logic [31:0]                wb_dat_q, wb_dat_d;

    logic       sck_s, cs_s, mosi_s;
    logic       sck_rise, sck_fall, cs_fall, cs_rise;
    logic       byte_done;
    logic [7:0] byte_val;

    always_comb begin
        sck_s     = sck_sync_q[SYNC_STAGES-1];
        cs_s      = cs_sync_q[SYNC_STAGES-1];
        mosi_s    = mosi_sync_q[SYNC_STAGES-1];
        sck_rise  = sck_s & ~sck_prev_q;
        sck_fall  = ~sck_s & sck_prev_q;
        cs_fall   = ~cs_s & cs_prev_q;
        cs_rise   = cs_s & ~cs_prev_q;
        byte_val  = {rx_q, mosi_s};
        byte_done = sck_rise && !cs_s && (bit_cnt_q == 3'd7);

        sck_sync_d   = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
        cs_sync_d    = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
        mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sck_prev_d   = sck_s;
        cs_prev_d    = cs_s;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_idx_d   = byte_idx_q;
        rx_d         = rx_q;
        is_read_d    = is_read_q;
        addr_d       = addr_q;
        tx_d         = tx_q;
        rd_valid_d   = rd_valid_q;
        first_fall_d = first_fall_q;
        blank_d      = blank_q;
        miso_d       = (state_q == ST_RDATA) ? miso_q : 1'b0;
        err_d        = err_q;
        wb_cyc_d     = wb_cyc_q;
        wb_we_d      = wb_we_q;
        wb_sel_d     = wb_sel_q;
        wb_adr_d     = wb_adr_q;
        wb_dat_d     = wb_dat_q;

        // Read data is kept only while the frame that asked for it is still open.
        if (wb_cyc_q && i_wb_ack) begin
            wb_cyc_d = 1'b0;
            wb_we_d  = 1'b0;
            wb_sel_d = 4'h0;
            if (!wb_we_q && !cs_rise && (state_q == ST_RWAIT || state_q == ST_RDATA)) begin
                tx_d       = {i_wb_rdt[7:0], i_wb_rdt[15:8], i_wb_rdt[23:16], i_wb_rdt[31:24]};
                rd_valid_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d    = ST_CMD;
                    bit_cnt_d  = 3'd0;
                    byte_idx_d = 2'd0;
                    err_d      = 1'b0;
                    rd_valid_d = 1'b0;
                    blank_d    = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (!wb_cyc_q || i_wb_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (sck_rise && !cs_s) begin
                    rx_d      = byte_val[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
                if (byte_done) begin
                    case (state_q)
                        ST_CMD: begin
                            byte_idx_d = 2'd0;
                            is_read_d  = (byte_val == CMD_READ);
                            state_d    = (byte_val == CMD_WRITE || byte_val == CMD_READ)
                                         ? ST_ADDR : ST_IGNORE;
                        end
                        ST_ADDR: begin
                            addr_d     = {addr_q[ADDRESS_WIDTH-9:0], byte_val};
                            byte_idx_d = byte_idx_q + 2'd1;
                            if (byte_idx_q == ADDR_LAST) begin
                                byte_idx_d = 2'd0;
                                wb_adr_d   = '0;
                                wb_adr_d[ADDRESS_WIDTH-1:2] = addr_d[ADDRESS_WIDTH-1:2];
                                if (is_read_q) begin
                                    state_d  = ST_RWAIT;
                                    wb_cyc_d = 1'b1;
                                    wb_we_d  = 1'b0;
                                    wb_sel_d = 4'hF;
                                end else begin
                                    state_d = ST_WDATA;
                                end
                            end
                        end
                        ST_WDATA: begin
                            wb_dat_d[{byte_idx_q, 3'b000} +: 8] = byte_val;
                            byte_idx_d = byte_idx_q + 2'd1;
                            if (byte_idx_q == 2'd3) begin
                                state_d  = ST_WB_WR;
                                wb_cyc_d = 1'b1;
                                wb_we_d  = 1'b1;
                                wb_sel_d = 4'hF;
                            end
                        end
                        ST_RWAIT: begin
                            state_d      = ST_RDATA;
                            first_fall_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
                // Data must be in hand by the fall that presents bit 7 of the first data byte.
                if (sck_fall && !cs_s && state_q == ST_RDATA) begin
                    first_fall_d = 1'b0;
                    if (first_fall_q && !rd_valid_q) begin
                        err_d   = 1'b1;
                        blank_d = 1'b1;
                    end else if (!blank_q) begin
                        miso_d = tx_q[31];
                        tx_d   = {tx_q[30:0], 1'b0};
                    end
                end
                if (cs_rise) begin
                    state_d = wb_cyc_d ? ST_DRAIN : ST_IDLE;
                end
            end
        endcase

        if (cs_s) begin
            miso_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q      <= ST_IDLE;
            sck_sync_q   <= '0;
            cs_sync_q    <= '1;
            mosi_sync_q  <= '0;
            sck_prev_q   <= 1'b0;
            cs_prev_q    <= 1'b1;
            bit_cnt_q    <= 3'd0;
            byte_idx_q   <= 2'd0;
            rx_q         <= 7'd0;
            is_read_q    <= 1'b0;
            addr_q       <= '0;
            tx_q         <= 32'd0;
            rd_valid_q   <= 1'b0;
            first_fall_q <= 1'b0;
            blank_q      <= 1'b0;
            miso_q       <= 1'b0;
            err_q        <= 1'b0;
            wb_cyc_q     <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_sel_q     <= 4'h0;
            wb_adr_q     <= 32'd0;
            wb_dat_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            sck_sync_q   <= sck_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sck_prev_q   <= sck_prev_d;
            cs_prev_q    <= cs_prev_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_idx_q   <= byte_idx_d;
            rx_q         <= rx_d;
            is_read_q    <= is_read_d;
            addr_q       <= addr_d;
            tx_q         <= tx_d;
            rd_valid_q   <= rd_valid_d;
            first_fall_q <= first_fall_d;
            blank_q      <= blank_d;
            miso_q       <= miso_d;
            err_q        <= err_d;
            wb_cyc_q     <= wb_cyc_d;
            wb_we_q      <= wb_we_d;
            wb_sel_q     <= wb_sel_d;
            wb_adr_q     <= wb_adr_d;
            wb_dat_q     <= wb_dat_d;
        end
    end

    assign spi_miso = miso_q;
    assign o_wb_cyc = wb_cyc_q;
    assign o_wb_we  = wb_we_q;
    assign o_wb_sel = wb_sel_q;
    assign o_wb_adr = wb_adr_q;
    assign o_wb_dat = wb_dat_q;
    assign o_err    = err_q;

endmodule

// File: tb/tb_servant_spi_wb_bridge.sv
// tb/tb_servant_spi_wb_bridge.sv - directed bench for servant_spi_wb_bridge
module tb_servant_spi_wb_bridge;

    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic        spi_sck, spi_cs, spi_mosi;
    logic        spi_miso;
    logic [31:0] o_wb_adr, o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we, o_wb_cyc;
    logic [31:0] i_wb_rdt;
    logic        i_wb_ack;
    logic        o_err;

    int total = 0;
    int bad   = 0;

    int          ack_delay = 2;
    int          wait_cnt;
    logic [31:0] rd_data = 32'd0;
    int          wb_count = 0;
    logic [31:0] last_adr, last_dat;
    logic        last_we;
    logic [3:0]  last_sel;
    logic [7:0]  rxb [0:15];

    servant_spi_wb_bridge dut (
        .wb_clk   (wb_clk),
        .wb_rst   (wb_rst),
        .spi_sck  (spi_sck),
        .spi_cs   (spi_cs),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .o_wb_adr (o_wb_adr),
        .o_wb_dat (o_wb_dat),
        .o_wb_sel (o_wb_sel),
        .o_wb_we  (o_wb_we),
        .o_wb_cyc (o_wb_cyc),
        .i_wb_rdt (i_wb_rdt),
        .i_wb_ack (i_wb_ack),
        .o_err    (o_err)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Wishbone slave: acks ack_delay cycles after cyc and records the transfer.
    initial begin
        i_wb_ack = 1'b0;
        i_wb_rdt = 32'd0;
        wait_cnt = 0;
        forever begin
            @(negedge wb_clk);
            if (i_wb_ack) begin
                i_wb_ack = 1'b0;
            end else if (o_wb_cyc && !wb_rst) begin
                if (wait_cnt >= ack_delay) begin
                    i_wb_ack = 1'b1;
                    i_wb_rdt = rd_data;
                    last_adr = o_wb_adr;
                    last_dat = o_wb_dat;
                    last_we  = o_wb_we;
                    last_sel = o_wb_sel;
                    wb_count++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = tx[i];
            repeat (4) @(negedge wb_clk);
            rx[i]   = spi_miso;
            spi_sck = 1'b1;
            repeat (4) @(negedge wb_clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [127:0] bytes, input int n);
        logic [7:0] r;
        logic [7:0] t;
        spi_cs = 1'b0;
        repeat (4) @(negedge wb_clk);
        for (int i = 0; i < n; i++) begin
            t = bytes[127 - 8*i -: 8];
            spi_byte(t, r);
            rxb[i] = r;
        end
        repeat (4) @(negedge wb_clk);
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;
        repeat (8) @(negedge wb_clk);
    endtask

    task automatic wait_wb(input string tag, input int target, input int budget);
        int k = 0;
        while (wb_count < target && k < budget) begin
            @(negedge wb_clk);
            k++;
        end
        repeat (4) @(negedge wb_clk);
        check(tag, wb_count, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"}, {31'd0, spi_miso}, 32'd0);
        check({tag, "_cyc"},  {31'd0, o_wb_cyc}, 32'd0);
        check({tag, "_we"},   {31'd0, o_wb_we},  32'd0);
        check({tag, "_adr"},  o_wb_adr,          32'd0);
        check({tag, "_dat"},  o_wb_dat,          32'd0);
        check({tag, "_sel"},  {28'd0, o_wb_sel}, 32'd0);
        check({tag, "_err"},  {31'd0, o_err},    32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        wb_rst   = 1'b1;
        spi_sck  = 1'b0;
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;
        repeat (4) @(negedge wb_clk);
        check_reset_outputs("rst");
        wb_rst = 1'b0;
        repeat (4) @(negedge wb_clk);

        // Write 0x12345678 to 0x1004
        n0 = wb_count;
        run_frame({8'h02, 8'h00, 8'h10, 8'h04, 8'h78, 8'h56, 8'h34, 8'h12, 64'd0}, 8);
        wait_wb("wr_count", n0 + 1, 100);
        check("wr_adr", last_adr, 32'h0000_1004);
        check("wr_dat", last_dat, 32'h1234_5678);
        check("wr_sel", {28'd0, last_sel}, 32'hF);
        check("wr_we", {31'd0, last_we}, 32'd1);
        check("wr_cyc_end", {31'd0, o_wb_cyc}, 32'd0);

        // Read 0x2008 returning 0xCAFEBABE
        n0 = wb_count;
        rd_data = 32'hCAFE_BABE;
        run_frame({8'h03, 8'h00, 8'h20, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 56'd0}, 9);
        wait_wb("rd_count", n0 + 1, 100);
        check("rd_b0", {24'd0, rxb[5]}, 32'hBE);
        check("rd_b1", {24'd0, rxb[6]}, 32'hBA);
        check("rd_b2", {24'd0, rxb[7]}, 32'hFE);
        check("rd_b3", {24'd0, rxb[8]}, 32'hCA);
        check("rd_adr", last_adr, 32'h0000_2008);
        check("rd_we", {31'd0, last_we}, 32'd0);
        check("rd_err", {31'd0, o_err}, 32'd0);

        // Abort after partial address, then a good frame
        n0 = wb_count;
        run_frame({8'h02, 8'h00, 8'h10, 104'd0}, 3);
        repeat (50) @(negedge wb_clk);
        check("abort_count", wb_count, n0);
        check("abort_cyc", {31'd0, o_wb_cyc}, 32'd0);
        run_frame({8'h02, 8'h00, 8'h00, 8'h40, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 64'd0}, 8);
        wait_wb("post_abort_count", n0 + 1, 100);
        check("post_abort_adr", last_adr, 32'h0000_0040);
        check("post_abort_dat", last_dat, 32'hDEAD_BEEF);

        // Unknown command
        n0 = wb_count;
        run_frame({8'h55, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 56'd0}, 9);
        repeat (50) @(negedge wb_clk);
        check("badcmd_count", wb_count, n0);
        check("badcmd_miso_lo", {rxb[1], rxb[2], rxb[3], rxb[4]}, 32'd0);
        check("badcmd_miso_hi", {rxb[5], rxb[6], rxb[7], rxb[8]}, 32'd0);

        // Late ack: data not ready at first data-byte shift
        n0 = wb_count;
        ack_delay = 200;
        rd_data   = 32'h1234_5678;
        run_frame({8'h03, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 56'd0}, 9);
        wait_wb("late_count", n0 + 1, 600);
        check("late_err", {31'd0, o_err}, 32'd1);
        check("late_miso", {rxb[5], rxb[6], rxb[7], rxb[8]}, 32'd0);
        check("late_cyc_end", {31'd0, o_wb_cyc}, 32'd0);

        // Reset while a write cycle is outstanding
        ack_delay = 100000;
        run_frame({8'h02, 8'h00, 8'h00, 8'h80, 8'h01, 8'h02, 8'h03, 8'h04, 64'd0}, 8);
        check("err_cleared", {31'd0, o_err}, 32'd0);
        check("hold_cyc", {31'd0, o_wb_cyc}, 32'd1);
        check("hold_dat", o_wb_dat, 32'h0403_0201);
        wb_rst = 1'b1;
        @(negedge wb_clk);
        check_reset_outputs("midrst");
        wb_rst = 1'b0;
        ack_delay = 2;
        repeat (4) @(negedge wb_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
